// File: rtl/gpu_pkg.sv
// Shared definitions for the gpu cores and the shared memory controller.
package gpu_pkg;
  localparam int N_CORES = 16;
  localparam int ADDR_W  = 12;
  localparam int DATA_W  = 8;

  typedef enum logic [3:0] {LD = 4'd11, ST = 4'd13} op_t;
  typedef enum logic [1:0] {IDLE, GRANT_ACC, DONE} state_t;
  typedef enum logic {CORE, HOST} src_t;
endpackage

// File: rtl/rr_arbiter.sv
// Combinational round-robin arbiter: first requester at or after ptr, wrapping.
module rr_arbiter #(
  parameter int N = gpu_pkg::N_CORES,
  parameter int IDW = $clog2(N)
) (
  input  logic [N-1:0]   req,
  input  logic [IDW-1:0] ptr,
  input  logic           enable,
  output logic [N-1:0]   grant,
  output logic [IDW-1:0] grant_id,
  output logic           any
);
  int             sum;
  logic [IDW-1:0] idx;

  always_comb begin
    grant    = '0;
    grant_id = '0;
    any      = 1'b0;
    sum      = 0;
    idx      = '0;
    if (enable) begin
      for (int i = 0; i < N; i++) begin
        sum = int'(ptr) + i;
        if (sum >= N) sum = sum - N;
        idx = IDW'(sum);
        if (!any && req[idx]) begin
          any        = 1'b1;
          grant_id   = idx;
          grant[idx] = 1'b1;
        end
      end
    end
  end
endmodule

// File: rtl/shared_mem_ctrl.sv
// Shared 8-bit single-port memory with host-priority, round-robin core access.
// Valid/ready: requests are levels sampled only in IDLE; each grant yields one ack pulse two edges later.
module shared_mem_ctrl #(
  parameter int N_CORES = gpu_pkg::N_CORES,
  parameter int ADDR_W  = gpu_pkg::ADDR_W,
  parameter int DATA_W  = gpu_pkg::DATA_W
) (
  input  logic                        clk,
  input  logic                        reset,
  input  logic [N_CORES-1:0]          req_ld,
  input  logic [N_CORES-1:0]          req_st,
  input  logic [N_CORES*ADDR_W-1:0]   core_addr,
  input  logic [N_CORES*DATA_W-1:0]   core_wdata,
  output logic [N_CORES-1:0]          val_data,
  output logic [DATA_W-1:0]           rdata,
  input  logic                        hst_req,
  input  logic                        hst_we,
  input  logic [ADDR_W-1:0]           hst_addr,
  input  logic [DATA_W-1:0]           hst_wdata,
  output logic                        hst_ack,
  output logic                        busy,
  output logic                        err_both,
  output gpu_pkg::state_t             dbg_state
);
  import gpu_pkg::*;

  localparam int IDW = $clog2(N_CORES);

  state_t            state, state_nx;
  logic [IDW-1:0]    rr_ptr, cur_id, ptr_nx;
  src_t              cur_src;
  op_t               cur_op;
  logic [ADDR_W-1:0] cur_addr;
  logic [DATA_W-1:0] cur_wdata;
  logic [DATA_W-1:0] mem [2**ADDR_W];

  logic [N_CORES-1:0] core_req, grant;
  logic [IDW-1:0]     grant_id;
  logic               any_core, both_bits;

  assign core_req  = req_ld | req_st;
  assign both_bits = |(grant & req_ld & req_st);
  assign ptr_nx    = (grant_id == IDW'(N_CORES - 1)) ? '0 : grant_id + 1'b1;
  assign busy      = (state == GRANT_ACC) || (state == DONE);
  assign dbg_state = state;

  rr_arbiter #(.N(N_CORES), .IDW(IDW)) u_arb (
    .req      (core_req),
    .ptr      (rr_ptr),
    .enable   ((state == IDLE) && !hst_req),
    .grant    (grant),
    .grant_id (grant_id),
    .any      (any_core)
  );

  always_comb begin
    state_nx = state;
    case (state)
      IDLE:      if (hst_req || any_core) state_nx = GRANT_ACC;
      GRANT_ACC: state_nx = DONE;
      DONE:      state_nx = IDLE;
      default:   state_nx = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state     <= IDLE;
      rr_ptr    <= '0;
      cur_id    <= '0;
      cur_src   <= CORE;
      cur_op    <= LD;
      cur_addr  <= '0;
      cur_wdata <= '0;
      val_data  <= '0;
      rdata     <= '0;
      hst_ack   <= 1'b0;
      err_both  <= 1'b0;
    end else begin
      state    <= state_nx;
      val_data <= '0;
      hst_ack  <= 1'b0;
      case (state)
        IDLE: begin
          if (hst_req) begin
            cur_src   <= HOST;
            cur_op    <= hst_we ? ST : LD;
            cur_addr  <= hst_addr;
            cur_wdata <= hst_wdata;
          end else if (any_core) begin
            cur_src   <= CORE;
            cur_id    <= grant_id;
            cur_op    <= req_st[grant_id] ? ST : LD;
            cur_addr  <= core_addr[int'(grant_id)*ADDR_W +: ADDR_W];
            cur_wdata <= core_wdata[int'(grant_id)*DATA_W +: DATA_W];
            rr_ptr    <= ptr_nx;
            if (both_bits) err_both <= 1'b1;
          end
        end
        GRANT_ACC: begin
          if (cur_op == LD) rdata <= mem[cur_addr];
          if (cur_src == HOST) hst_ack <= 1'b1;
          else                 val_data[cur_id] <= 1'b1;
        end
        default: ;
      endcase
    end
  end

  // Memory has no reset; a reset edge during GRANT_ACC drops the pending store.
  always_ff @(posedge clk) begin
    if (!reset && state == GRANT_ACC && cur_op == ST) mem[cur_addr] <= cur_wdata;
  end
endmodule

// File: tb/tb_shared_mem_ctrl.sv
// Directed bench for shared_mem_ctrl: host/core access, arbitration order, error flag, reset abort.
module tb_shared_mem_ctrl;
  import gpu_pkg::*;

  localparam int N  = 16;
  localparam int AW = 12;
  localparam int DW = 8;

  logic            clk, reset;
  logic [N-1:0]    req_ld, req_st, val_data;
  logic [N*AW-1:0] core_addr;
  logic [N*DW-1:0] core_wdata;
  logic [DW-1:0]   rdata, hst_wdata;
  logic [AW-1:0]   hst_addr;
  logic            hst_req, hst_we, hst_ack, busy, err_both;
  state_t          dbg_state;

  shared_mem_ctrl dut (
    .clk(clk), .reset(reset), .req_ld(req_ld), .req_st(req_st),
    .core_addr(core_addr), .core_wdata(core_wdata), .val_data(val_data),
    .rdata(rdata), .hst_req(hst_req), .hst_we(hst_we), .hst_addr(hst_addr),
    .hst_wdata(hst_wdata), .hst_ack(hst_ack), .busy(busy),
    .err_both(err_both), .dbg_state(dbg_state)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail   = 0;
  int ovl_cnt  = 0;
  logic [15:0] exp_q[$];

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  always @(negedge clk)
    if (!reset && (($countones(val_data) > 1) || (val_data != 0 && hst_ack))) ovl_cnt++;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    reset = 1'b1; hst_req = 1'b0; req_ld = '0; req_st = '0;
    tick(); tick();
    reset = 1'b0;
  endtask

  task automatic wait_idle();
    int k = 0;
    while (dbg_state != IDLE && k < 30) begin tick(); k++; end
  endtask

  task automatic wait_event(output logic [15:0] vd, output logic ha, output int cyc);
    cyc = 0; vd = '0; ha = 1'b0;
    while (cyc < 30) begin
      tick(); cyc++;
      if (val_data != 0 || hst_ack) begin vd = val_data; ha = hst_ack; break; end
    end
    if (vd == 0 && !ha) check("timeout", 32'd1, 32'd0);
  endtask

  task automatic host_op(input string tag, input logic we, input logic [AW-1:0] a,
                         input logic [DW-1:0] wd, output logic [DW-1:0] rd, output int cyc);
    logic [15:0] vd; logic ha;
    hst_req = 1'b1; hst_we = we; hst_addr = a; hst_wdata = wd;
    wait_event(vd, ha, cyc);
    rd = rdata;
    check({tag, "_ack"}, {31'd0, ha}, 32'd1);
    hst_req = 1'b0;
    tick();
    check({tag, "_ack_width"}, {31'd0, hst_ack}, 32'd0);
    wait_idle();
  endtask

  task automatic core_op(input string tag, input int id, input logic ld, input logic st,
                         input logic [AW-1:0] a, input logic [DW-1:0] wd,
                         output logic [15:0] vd, output logic [DW-1:0] rd, output int cyc);
    logic ha;
    core_addr[id*AW +: AW] = a; core_wdata[id*DW +: DW] = wd;
    req_ld[id] = ld; req_st[id] = st;
    wait_event(vd, ha, cyc);
    rd = rdata;
    req_ld[id] = 1'b0; req_st[id] = 1'b0;
    tick();
    check({tag, "_vd_width"}, {16'd0, val_data}, 32'd0);
    wait_idle();
  endtask

  logic [15:0] vd, served, one;
  logic        ha;
  logic [7:0]  rd;
  int          cyc;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    req_ld = '0; req_st = '0; core_addr = '0; core_wdata = '0;
    hst_req = 1'b0; hst_we = 1'b0; hst_addr = '0; hst_wdata = '0; reset = 1'b1;
    tick();
    do_reset();
    check("rst_val_data", {16'd0, val_data}, 32'd0);
    check("rst_rdata", {24'd0, rdata}, 32'd0);
    check("rst_hst_ack", {31'd0, hst_ack}, 32'd0);
    check("rst_busy", {31'd0, busy}, 32'd0);
    check("rst_err_both", {31'd0, err_both}, 32'd0);
    check("rst_state", {30'd0, dbg_state}, {30'd0, IDLE});

    // host preload, then core 3 reads it back
    host_op("h_wr123", 1'b1, 12'h123, 8'h5A, rd, cyc);
    check("h_wr_latency", cyc, 32'd2);
    core_op("c3_ld", 3, 1'b1, 1'b0, 12'h123, 8'h00, vd, rd, cyc);
    check("c3_vd", {16'd0, vd}, 32'h0008);
    check("c3_rdata", {24'd0, rd}, 32'h5A);
    check("c3_latency", cyc, 32'd2);

    // two simultaneous stores, pointer at 0
    do_reset();
    core_addr[2*AW +: AW] = 12'h010; core_wdata[2*DW +: DW] = 8'h11;
    core_addr[7*AW +: AW] = 12'h010; core_wdata[7*DW +: DW] = 8'h22;
    req_st[2] = 1'b1; req_st[7] = 1'b1;
    wait_event(vd, ha, cyc);
    check("st_first", {16'd0, vd}, 32'h0004);
    check("st_rdata_hold", {24'd0, rdata}, 32'h00);
    req_st[2] = 1'b0;
    wait_event(vd, ha, cyc);
    check("st_second", {16'd0, vd}, 32'h0080);
    req_st[7] = 1'b0;
    tick();
    wait_idle();
    host_op("h_rd010", 1'b0, 12'h010, 8'h00, rd, cyc);
    check("h_rd010_data", {24'd0, rd}, 32'h22);

    // all cores loading continuously: strict rotation from 0
    do_reset();
    for (int i = 0; i < N; i++) exp_q.push_back(16'(i));
    exp_q.push_back(16'd0);
    served = '0;
    req_ld = '1;
    for (int g = 0; g < N + 1; g++) begin
      wait_event(vd, ha, cyc);
      one = 16'd1 << exp_q.pop_front();
      check("rr_order", {16'd0, vd}, {16'd0, one});
      if (g < N) served = served | vd;
      req_ld = req_ld & ~vd;
      tick();
      req_ld = '1;
    end
    check("rr_all_served", {16'd0, served}, 32'hFFFF);
    req_ld = '0;
    tick();
    wait_idle();

    // both request bits: store wins, error is sticky
    core_op("c5_both", 5, 1'b1, 1'b1, 12'h0FF, 8'hAB, vd, rd, cyc);
    check("c5_vd", {16'd0, vd}, 32'h0020);
    check("err_both_set", {31'd0, err_both}, 32'd1);
    core_op("c1_ld", 1, 1'b1, 1'b0, 12'h0FF, 8'h00, vd, rd, cyc);
    check("c1_rdata", {24'd0, rd}, 32'hAB);
    check("err_both_sticky", {31'd0, err_both}, 32'd1);

    // host beats core 0 in the same cycle; memory survived the resets
    hst_req = 1'b1; hst_we = 1'b0; hst_addr = 12'h123;
    core_addr[0 +: AW] = 12'h010; req_ld[0] = 1'b1;
    wait_event(vd, ha, cyc);
    check("prio_host_first", {31'd0, ha}, 32'd1);
    check("prio_no_core", {16'd0, vd}, 32'd0);
    check("prio_host_rdata", {24'd0, rdata}, 32'h5A);
    hst_req = 1'b0;
    wait_event(vd, ha, cyc);
    check("prio_core0", {16'd0, vd}, 32'h0001);
    check("prio_core0_rdata", {24'd0, rdata}, 32'h22);
    req_ld[0] = 1'b0;
    tick();
    wait_idle();

    // reset during GRANT_ACC of a core-4 store
    host_op("h_wr200", 1'b1, 12'h200, 8'h33, rd, cyc);
    core_addr[4*AW +: AW] = 12'h200; core_wdata[4*DW +: DW] = 8'h99;
    req_st[4] = 1'b1;
    tick();
    check("abort_in_grant", {30'd0, dbg_state}, {30'd0, GRANT_ACC});
    reset = 1'b1; req_st = '0;
    tick();
    check("abort_val_data", {16'd0, val_data}, 32'd0);
    check("abort_busy", {31'd0, busy}, 32'd0);
    check("abort_rdata", {24'd0, rdata}, 32'd0);
    check("abort_err_clr", {31'd0, err_both}, 32'd0);
    reset = 1'b0;
    host_op("h_rd200", 1'b0, 12'h200, 8'h00, rd, cyc);
    check("abort_mem_kept", {24'd0, rd}, 32'h33);
    req_ld[0] = 1'b1; req_ld[6] = 1'b1;
    wait_event(vd, ha, cyc);
    check("abort_ptr_zero", {16'd0, vd}, 32'h0001);
    req_ld = '0;
    tick();
    wait_idle();

    check("no_overlap", ovl_cnt, 32'd0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
